vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator and output stage for the TQV peripheral harness.
- Replaces fixed 640x480 sync logic with configurable timing, sync polarity, pixel-clock divider and colour depth.
- Drives the packed {vsync, hsync, B, G, R} word that maps onto uo_out.
- Provides x/y/de to the sprite/pixel source, frame and line strobes, and a sticky programmable line interrupt.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_pix_div.sv | 28 ++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, total helpers and vga_out field positions for the
// VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_COLOR_BITS = 2;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // vga_out is {vsync, hsync, B, G, R}; each channel is cb bits wide.
    function automatic int chan_lsb(int cb, int ch);
        return ch * cb;
    endfunction

    function automatic int hsync_bit(int cb);
        return 3 * cb;
    endfunction

    function automatic int vsync_bit(int cb);
        return 3 * cb + 1;
    endfunction

    localparam int HSYNC_BIT = hsync_bit(DEF_COLOR_BITS);
    localparam int VSYNC_BIT = vsync_bit(DEF_COLOR_BITS);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source / output-pin side of the VGA timing generator; the generator
// itself uses the slave modport.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10,
    parameter int CW = 6
);
    localparam int OW = CW + 2;

    logic          en;
    logic [CW-1:0] rgb_in;
    logic [VW-1:0] irq_line;
    logic          irq_line_en;
    logic          irq_ack;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          de;
    logic          pix_en;
    logic          line_start;
    logic          frame_start;
    logic          line_irq;
    logic [OW-1:0] vga_out;

    modport master (
        output en, rgb_in, irq_line, irq_line_en, irq_ack,
        input  x, y, de, pix_en, line_start, frame_start, line_irq, vga_out
    );

    modport slave (
        input  en, rgb_in, irq_line, irq_line_en, irq_ack,
        output x, y, de, pix_en, line_start, frame_start, line_irq, vga_out
    );

endinterface

// File: rtl/vga_pix_div.sv
// Pixel-clock divider: pix_en_o fires on the last of every CLK_DIV enabled clocks.
module vga_pix_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic pix_en_o
);
    // With CLK_DIV=1 the counter is a constant 0, so pix_en_o reduces to en_i.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (en_i) div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    assign pix_en_o = en_i && (div_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Configurable VGA timing generator: x/y counters, sync decode, registered
// {vsync, hsync, B, G, R} output stage and a sticky line interrupt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int COLOR_BITS = DEF_COLOR_BITS
) (
    input logic clk,
    input logic rst,
    vga_timing_gen_if.slave bus
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = 3 * COLOR_BITS;
    localparam int OW      = CW + 2;
    localparam int HS_BIT  = hsync_bit(COLOR_BITS);
    localparam int VS_BIT  = vsync_bit(COLOR_BITS);

    localparam logic [HW-1:0] X_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] Y_LAST = VW'(V_TOTAL - 1);

    // Decode bounds carry one extra bit so a zero back porch cannot overflow.
    localparam logic [HW:0] X_ACT  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] Y_ACT  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [OW-1:0] VGA_RST = {~VSYNC_POL, ~HSYNC_POL, {CW{1'b0}}};

    logic          pix_en;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic [OW-1:0] vga_q, vga_d;
    logic          line_irq_q, line_irq_d;
    logic          de_c, hs_c, vs_c, irq_set;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.en),
        .pix_en_o (pix_en)
    );

    always_comb begin
        de_c = ({1'b0, x_q} < X_ACT) && ({1'b0, y_q} < Y_ACT);
        hs_c = ({1'b0, x_q} >= HS_BEG && {1'b0, x_q} < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vs_c = ({1'b0, y_q} >= VS_BEG && {1'b0, y_q} < VS_END) ? VSYNC_POL : ~VSYNC_POL;

        x_d   = x_q;
        y_d   = y_q;
        vga_d = vga_q;
        if (pix_en) begin
            vga_d[VS_BIT]   = vs_c;
            vga_d[HS_BIT]   = hs_c;
            vga_d[CW-1:0]   = de_c ? bus.rgb_in : {CW{1'b0}};
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + VW'(1);
            end else begin
                x_d = x_q + HW'(1);
            end
        end

        // A set in the same cycle as an ack wins.
        irq_set    = pix_en && (x_q == '0) && (y_q == bus.irq_line) && bus.irq_line_en;
        line_irq_d = irq_set | (line_irq_q & ~bus.irq_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            vga_q      <= VGA_RST;
            line_irq_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            vga_q      <= vga_d;
            line_irq_q <= line_irq_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.de          = de_c;
    assign bus.pix_en      = pix_en;
    assign bus.line_start  = pix_en && (x_q == '0);
    assign bus.frame_start = pix_en && (x_q == '0) && (y_q == '0);
    assign bus.line_irq    = line_irq_q;
    assign bus.vga_out     = vga_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (divide-by-1 and
// divide-by-3 with active-high hsync) checked against an arithmetic model.
module tb_vga_timing_gen;
    localparam int HT = 16;
    localparam int VT = 11;
    localparam int HA = 8;
    localparam int VA = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [5:0] rgb = 6'h0;
    logic [3:0] irq_line = 4'd0;
    logic       irq_line_en = 1'b0;
    logic       irq_ack = 1'b0;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_gen_if #(.HW(4), .VW(4), .CW(6)) bus1 ();
    vga_timing_gen_if #(.HW(4), .VW(4), .CW(6)) bus3 ();

    assign bus1.en = en;          assign bus3.en = en;
    assign bus1.rgb_in = rgb;     assign bus3.rgb_in = rgb;
    assign bus1.irq_line = irq_line;       assign bus3.irq_line = irq_line;
    assign bus1.irq_line_en = irq_line_en; assign bus3.irq_line_en = irq_line_en;
    assign bus1.irq_ack = irq_ack;         assign bus3.irq_ack = irq_ack;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .COLOR_BITS(2)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(3), .COLOR_BITS(2)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pixel position follows from the number of enabled clocks since reset.
    int         div_of [2] = '{1, 3};
    bit         hpol   [2] = '{1'b0, 1'b1};
    int         e_cnt  [2];
    logic [7:0] m_vga  [2];
    bit         m_irq  [2];

    function automatic int mp(int d);   return e_cnt[d] / div_of[d];             endfunction
    function automatic int mx(int d);   return mp(d) % HT;                       endfunction
    function automatic int my(int d);   return (mp(d) / HT) % VT;                endfunction
    function automatic bit mpix(int d); return en && (e_cnt[d] % div_of[d] == div_of[d] - 1); endfunction
    function automatic bit mde(int d);  return (mx(d) < HA) && (my(d) < VA);     endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            bit pix;
            int xx, yy;
            if (rst) begin
                e_cnt[d] = 0;
                m_vga[d] = {1'b1, ~hpol[d], 6'h0};
                m_irq[d] = 1'b0;
            end else begin
                pix = mpix(d);
                xx  = mx(d);
                yy  = my(d);
                if (pix)
                    m_vga[d] = {(yy >= VA + 1 && yy < VA + 3) ? 1'b0 : 1'b1,
                                (xx >= HA + 2 && xx < HA + 5) ? hpol[d] : ~hpol[d],
                                mde(d) ? rgb : 6'h0};
                if (pix && xx == 0 && yy == int'(irq_line) && irq_line_en) m_irq[d] = 1'b1;
                else if (irq_ack) m_irq[d] = 1'b0;
                if (en) e_cnt[d]++;
            end
        end
    end

    task automatic cmp(int d, logic [3:0] x, logic [3:0] y, logic de, logic pe, logic ls,
                       logic fs, logic irq, logic [7:0] vga);
        check($sformatf("d%0d_x", d), 32'(x), mx(d));
        check($sformatf("d%0d_y", d), 32'(y), my(d));
        check($sformatf("d%0d_de", d), 32'(de), 32'(mde(d)));
        check($sformatf("d%0d_pix_en", d), 32'(pe), 32'(mpix(d)));
        check($sformatf("d%0d_line_start", d), 32'(ls), 32'(mpix(d) && mx(d) == 0));
        check($sformatf("d%0d_frame_start", d), 32'(fs), 32'(mpix(d) && mx(d) == 0 && my(d) == 0));
        check($sformatf("d%0d_line_irq", d), 32'(irq), 32'(m_irq[d]));
        check($sformatf("d%0d_vga_out", d), 32'(vga), 32'(m_vga[d]));
    endtask

    always @(negedge clk) begin
        cmp(0, bus1.x, bus1.y, bus1.de, bus1.pix_en, bus1.line_start, bus1.frame_start,
            bus1.line_irq, bus1.vga_out);
        cmp(1, bus3.x, bus3.y, bus3.de, bus3.pix_en, bus3.line_start, bus3.frame_start,
            bus3.line_irq, bus3.vga_out);
    end

    int         de_n, hs_n, vs_n, col_n, pe3, de3, hs3, vs3, irq_n, strobe_n;
    bit         found;
    logic [7:0] saved_vga;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", 32'(bus1.x), 0);
        check("rst_y", 32'(bus1.y), 0);
        check("rst_vga1", 32'(bus1.vga_out), 32'h0C0);
        check("rst_vga3", 32'(bus3.vga_out), 32'h080);
        check("rst_irq", 32'(bus1.line_irq), 0);

        rgb = 6'h3F;
        en  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("first_frame_start", 32'(bus1.frame_start), 1);
        check("colour_at_00", 32'(bus1.vga_out[5:0]), 0);
        @(negedge clk);
        check("x_after_one_pixel", 32'(bus1.x), 1);
        check("first_pixel_out", 32'(bus1.vga_out), 32'h0FF);

        // 528 clk = three frames of dut1, one frame of dut3.
        de_n = 0; hs_n = 0; vs_n = 0; col_n = 0; pe3 = 0; de3 = 0; hs3 = 0; vs3 = 0;
        repeat (528) begin
            @(negedge clk);
            de_n  += int'(bus1.de);
            hs_n  += int'(!bus1.vga_out[6]);
            vs_n  += int'(!bus1.vga_out[7]);
            col_n += int'(bus1.vga_out[5:0] != 6'h0);
            pe3   += int'(bus3.pix_en);
            de3   += int'(bus3.de);
            hs3   += int'(bus3.vga_out[6]);
            vs3   += int'(!bus3.vga_out[7]);
        end
        check("de1_clks", de_n, 144);
        check("hsync1_low_clks", hs_n, 99);
        check("vsync1_low_clks", vs_n, 96);
        check("colour1_clks", col_n, 144);
        check("pix_en3_count", pe3, 176);
        check("de3_clks", de3, 144);
        check("hsync3_high_clks", hs3, 99);
        check("vsync3_low_clks", vs3, 96);

        repeat (300) begin
            @(posedge clk);
            #1;
            rgb = 6'($urandom);
        end

        irq_line    = 4'd3;
        irq_line_en = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus1.x == 4'd0 && bus1.y == 4'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("irq_line_reached", 32'(found), 1);
        check("irq_before_set", 32'(bus1.line_irq), 0);
        irq_ack = 1'b1;
        @(posedge clk);
        #1;
        check("irq_set_beats_ack", 32'(bus1.line_irq), 1);
        @(posedge clk);
        #1;
        irq_ack = 1'b0;
        check("irq_ack_clears", 32'(bus1.line_irq), 0);

        irq_line = 4'd12;
        irq_ack  = 1'b1;
        @(posedge clk);
        #1;
        irq_ack = 1'b0;
        irq_n   = 0;
        repeat (528) begin
            @(negedge clk);
            irq_n += int'(bus1.line_irq) + int'(bus3.line_irq);
        end
        check("irq_out_of_range_silent", irq_n, 0);

        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus1.x == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("en_drop_x_reached", 32'(found), 1);
        en        = 1'b0;
        saved_vga = bus1.vga_out;
        strobe_n  = 0;
        repeat (7) begin
            @(posedge clk);
            #1;
            check("en_low_x_hold", 32'(bus1.x), 5);
            check("en_low_vga_hold", 32'(bus1.vga_out), 32'(saved_vga));
            strobe_n += int'(bus1.pix_en) + int'(bus1.line_start) + int'(bus1.frame_start);
        end
        check("en_low_no_strobes", strobe_n, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("en_resume_x", 32'(bus1.x), 6);

        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus1.x == 4'd5 && bus1.y == 4'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("midframe_reached", 32'(found), 1);
        rst = 1'b1;
        #1;
        check("async_rst_x", 32'(bus1.x), 0);
        check("async_rst_y", 32'(bus1.y), 0);
        check("async_rst_vga1", 32'(bus1.vga_out), 32'h0C0);
        check("async_rst_vga3", 32'(bus3.vga_out), 32'h080);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pix_en", 32'(bus1.pix_en), 1);
        check("post_rst_frame_start", 32'(bus1.frame_start), 1);

        repeat (60) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
